// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared widths, state encoding and divide-by-zero constants
package fp_div_pkg;

   localparam int MANT_W = 24;
   localparam int EXP_W  = 8;
   localparam int BIAS   = 127;
   localparam int QUO_W  = 2 * MANT_W;
   localparam int REM_W  = MANT_W + 2;
   localparam int CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FAST,
      DONE
   } div_state_t;

   localparam logic [QUO_W-1:0] DBZ_MANT = {1'b0, {(QUO_W-1){1'b1}}};
   localparam logic [EXP_W+1:0] DBZ_EXP  = (EXP_W+2)'(255);

endpackage

// File: rtl/fp_div_mantissa_seq_if.sv
// rtl/fp_div_mantissa_seq_if.sv - operand/handshake/result bundle of the mantissa divider
interface fp_div_mantissa_seq_if
   import fp_div_pkg::*;
();

   logic               en;
   logic               start;
   logic [MANT_W-1:0]  mant_a;
   logic [MANT_W-1:0]  mant_b;
   logic [EXP_W-1:0]   exp_a;
   logic [EXP_W-1:0]   exp_b;
   logic               busy;
   logic               done;
   logic               div_by_zero;
   logic [QUO_W-1:0]   mantisa_mul;
   logic [EXP_W+1:0]   exponent_add;
   logic               sel;

   modport master (
      output en, start, mant_a, mant_b, exp_a, exp_b,
      input  busy, done, div_by_zero, mantisa_mul, exponent_add, sel
   );

   modport slave (
      input  en, start, mant_a, mant_b, exp_a, exp_b,
      output busy, done, div_by_zero, mantisa_mul, exponent_add, sel
   );

endinterface

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational restoring-division step
module div_restoring_step
   import fp_div_pkg::*;
(
   input  logic [REM_W-1:0]  rem,
   input  logic [MANT_W-1:0] divisor,
   output logic              q_bit,
   output logic [REM_W-1:0]  rem_next
);

   // One extra bit so the sign of the trial difference is visible.
   logic [REM_W:0] trial;

   assign trial    = {1'b0, rem} - {{(REM_W-MANT_W+1){1'b0}}, divisor};
   assign q_bit    = ~trial[REM_W];
   assign rem_next = q_bit ? {trial[REM_W-2:0], 1'b0} : {rem[REM_W-2:0], 1'b0};

endmodule

// File: rtl/fp_div_mantissa_seq.sv
// rtl/fp_div_mantissa_seq.sv - bit-serial restoring mantissa divider feeding the normalizer
module fp_div_mantissa_seq
   import fp_div_pkg::*;
(
   input  logic                  clk,
   input  logic                  arst,
   fp_div_mantissa_seq_if.slave  bus
);

   div_state_t         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [REM_W-1:0]   rem, rem_n;
   logic [MANT_W-1:0]  dvs, dvs_n;
   logic [QUO_W-2:0]   quo, quo_n;
   logic [EXP_W+1:0]   exp_r, exp_n;
   logic               b_zero, b_zero_n;
   logic               busy_q, busy_n;
   logic               done_q, done_n;
   logic               dbz_q, dbz_n;
   logic [QUO_W-1:0]   mant_q, mant_n;
   logic [EXP_W+1:0]   expo_q, expo_n;
   logic               sel_q, sel_n;

   logic               q_bit;
   logic [REM_W-1:0]   rem_next;
   logic               adj;
   logic [EXP_W+1:0]   exp_calc;

   div_restoring_step u_step (
      .rem      (rem),
      .divisor  (dvs),
      .q_bit    (q_bit),
      .rem_next (rem_next)
   );

   // Prescale keeps the quotient in [1,2), so bit 46 is always the leading one.
   assign adj      = bus.mant_a < bus.mant_b;
   assign exp_calc = {2'b00, bus.exp_a} - {2'b00, bus.exp_b} + (EXP_W+2)'(BIAS)
                   - {{(EXP_W+1){1'b0}}, adj};

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rem_n    = rem;
      dvs_n    = dvs;
      quo_n    = quo;
      exp_n    = exp_r;
      b_zero_n = b_zero;
      busy_n   = busy_q;
      done_n   = 1'b0;
      dbz_n    = dbz_q;
      mant_n   = mant_q;
      expo_n   = expo_q;
      sel_n    = sel_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               rem_n    = adj ? {1'b0, bus.mant_a, 1'b0} : {2'b00, bus.mant_a};
               dvs_n    = bus.mant_b;
               quo_n    = '0;
               exp_n    = exp_calc;
               b_zero_n = (bus.mant_b == '0);
               cnt_n    = CNT_W'(QUO_W - 2);
               busy_n   = 1'b1;
               dbz_n    = 1'b0;
               state_n  = (bus.mant_a == '0 || bus.mant_b == '0) ? FAST : CALC;
            end
         end
         CALC: begin
            quo_n[cnt] = q_bit;
            rem_n      = rem_next;
            if (cnt == '0) begin
               // Sticky: any leftover remainder marks the result inexact.
               quo_n[0] = q_bit | (rem_next != '0);
               mant_n   = {1'b0, quo_n};
               expo_n   = exp_r;
               sel_n    = 1'b1;
               busy_n   = 1'b0;
               done_n   = 1'b1;
               state_n  = DONE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         FAST: begin
            if (b_zero) begin
               dbz_n  = 1'b1;
               mant_n = DBZ_MANT;
               expo_n = DBZ_EXP;
            end else begin
               mant_n = '0;
               expo_n = '0;
            end
            sel_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state  <= IDLE;
         cnt    <= '0;
         rem    <= '0;
         dvs    <= '0;
         quo    <= '0;
         exp_r  <= '0;
         b_zero <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         mant_q <= '0;
         expo_q <= '0;
         sel_q  <= 1'b0;
      end else if (bus.en) begin
         state  <= state_n;
         cnt    <= cnt_n;
         rem    <= rem_n;
         dvs    <= dvs_n;
         quo    <= quo_n;
         exp_r  <= exp_n;
         b_zero <= b_zero_n;
         busy_q <= busy_n;
         done_q <= done_n;
         dbz_q  <= dbz_n;
         mant_q <= mant_n;
         expo_q <= expo_n;
         sel_q  <= sel_n;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.div_by_zero  = dbz_q;
   assign bus.mantisa_mul  = mant_q;
   assign bus.exponent_add = expo_q;
   assign bus.sel          = sel_q;

endmodule

// File: tb/tb_fp_div_mantissa_seq.sv
// tb/tb_fp_div_mantissa_seq.sv - randomized and directed checks of the mantissa divider
module tb_fp_div_mantissa_seq;
   import fp_div_pkg::*;

   logic clk;
   logic arst;
   int   n_checks;
   int   n_pass;

   fp_div_mantissa_seq_if dif ();

   fp_div_mantissa_seq dut (
      .clk  (clk),
      .arst (arst),
      .bus  (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [47:0] q;
      logic [9:0]  e;
      logic        dz;
      int          lat;
   } vec_t;

   function automatic void ref_div(input logic [23:0] a, input logic [23:0] b,
                                   input logic [7:0] ea, input logic [7:0] eb,
                                   output logic [47:0] q, output logic [9:0] e,
                                   output logic dz);
      logic [79:0] num;
      logic [79:0] den;
      int          adj;
      int          ei;
      if (b == 0) begin
         q = 48'h7FFF_FFFF_FFFF; e = 10'h0FF; dz = 1'b1;
      end else if (a == 0) begin
         q = '0; e = '0; dz = 1'b0;
      end else begin
         adj = (a < b) ? 1 : 0;
         num = 80'(a) * ((adj == 1) ? 80'd2 : 80'd1);
         num = num << 46;
         den = 80'(b);
         q   = 48'(num / den);
         if ((num % den) != 0) q[0] = 1'b1;
         ei  = int'(ea) - int'(eb) + 127 - adj;
         e   = 10'(ei);
         dz  = 1'b0;
      end
   endfunction

   task automatic run_div(input logic [23:0] a, input logic [23:0] b,
                          input logic [7:0] ea, input logic [7:0] eb, output int cyc);
      @(negedge clk);
      dif.mant_a = a; dif.mant_b = b; dif.exp_a = ea; dif.exp_b = eb;
      dif.start  = 1'b1;
      @(negedge clk);
      dif.start = 1'b0;
      cyc = 1;
      while (dif.done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      arst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.sel !== 1'b0 || dif.div_by_zero !== 1'b0)
         $display("FAIL reset_ctrl busy=%b done=%b sel=%b dbz=%b required all 0",
                  dif.busy, dif.done, dif.sel, dif.div_by_zero);
      else n_pass++;
      n_checks++;
      if (dif.mantisa_mul !== 48'h0 || dif.exponent_add !== 10'h0)
         $display("FAIL reset_data mant=%h exp=%h required 0/0", dif.mantisa_mul, dif.exponent_add);
      else n_pass++;
      arst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      vec_t v [5];
      int   cyc;
      v[0] = '{24'hC00000, 24'h800000, 8'd127, 8'd127, 48'h6000_0000_0000, 10'd127, 1'b0, 48};
      v[1] = '{24'h800000, 24'hC00000, 8'd127, 8'd127, 48'h5555_5555_5555, 10'd126, 1'b0, 48};
      v[2] = '{24'h800000, 24'h800000, 8'd1,   8'd254, 48'h4000_0000_0000, 10'h382,  1'b0, 48};
      v[3] = '{24'h000000, 24'h800000, 8'd100, 8'd50,  48'h0,              10'h000,  1'b0, 2};
      v[4] = '{24'h800000, 24'h000000, 8'd100, 8'd50,  48'h7FFF_FFFF_FFFF, 10'h0FF,  1'b1, 2};
      for (int i = 0; i < 5; i++) begin
         run_div(v[i].a, v[i].b, v[i].ea, v[i].eb, cyc);
         n_checks++;
         if (cyc != v[i].lat) $display("FAIL dir%0d_latency got %0d required %0d", i, cyc, v[i].lat);
         else n_pass++;
         n_checks++;
         if (dif.mantisa_mul !== v[i].q || dif.exponent_add !== v[i].e ||
             dif.div_by_zero !== v[i].dz || dif.sel !== 1'b1 || dif.busy !== 1'b0)
            $display("FAIL dir%0d_result mant=%h exp=%h dbz=%b sel=%b busy=%b required %h %h %b 1 0",
                     i, dif.mantisa_mul, dif.exponent_add, dif.div_by_zero, dif.sel, dif.busy,
                     v[i].q, v[i].e, v[i].dz);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if (dif.done !== 1'b0 || dif.mantisa_mul !== v[i].q)
            $display("FAIL dir%0d_hold done=%b mant=%h required 0 %h", i, dif.done, dif.mantisa_mul, v[i].q);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [23:0] a, b;
      logic [7:0]  ea, eb;
      logic [47:0] q;
      logic [9:0]  e;
      logic        dz;
      int          cyc, lat;
      for (int i = 0; i < 24; i++) begin
         a  = {1'b1, 23'($urandom)};
         b  = {1'b1, 23'($urandom)};
         if (i % 6 == 1) b = a;
         if (i % 8 == 3) a = '0;
         if (i % 8 == 5) b = '0;
         ea = 8'($urandom);
         eb = 8'($urandom);
         ref_div(a, b, ea, eb, q, e, dz);
         lat = (a == 0 || b == 0) ? 2 : 48;
         run_div(a, b, ea, eb, cyc);
         n_checks++;
         if (cyc != lat) $display("FAIL rnd%0d_latency got %0d required %0d", i, cyc, lat);
         else n_pass++;
         n_checks++;
         if (dif.mantisa_mul !== q || dif.exponent_add !== e || dif.div_by_zero !== dz || dif.sel !== 1'b1)
            $display("FAIL rnd%0d_result a=%h b=%h mant=%h exp=%h dbz=%b sel=%b required %h %h %b 1",
                     i, a, b, dif.mantisa_mul, dif.exponent_add, dif.div_by_zero, dif.sel, q, e, dz);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_enable_stall();
      int cyc;
      int bad;
      @(negedge clk);
      dif.mant_a = 24'hC00000; dif.mant_b = 24'h800000; dif.exp_a = 8'd127; dif.exp_b = 8'd127;
      dif.start = 1'b1;
      @(negedge clk);
      dif.start = 1'b0;
      cyc = 1;
      repeat (5) begin @(negedge clk); cyc++; end
      dif.en = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk); cyc++;
         if (dif.busy !== 1'b1 || dif.done !== 1'b0) bad++;
      end
      dif.en = 1'b1;
      n_checks++;
      if (bad != 0) $display("FAIL stall_freeze bad_cycles=%0d required 0", bad);
      else n_pass++;
      while (dif.done !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
      n_checks++;
      if (cyc != 58) $display("FAIL stall_latency got %0d required 58", cyc);
      else n_pass++;
      n_checks++;
      if (dif.mantisa_mul !== 48'h6000_0000_0000 || dif.exponent_add !== 10'd127)
         $display("FAIL stall_result mant=%h exp=%h required 600000000000 07f",
                  dif.mantisa_mul, dif.exponent_add);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int cyc;
      @(negedge clk);
      dif.mant_a = 24'hC00000; dif.mant_b = 24'h800000; dif.exp_a = 8'd127; dif.exp_b = 8'd127;
      dif.start = 1'b1;
      @(negedge clk);
      dif.start = 1'b0;
      cyc = 1;
      repeat (9) begin @(negedge clk); cyc++; end
      dif.mant_a = 24'h800000; dif.mant_b = 24'hC00000; dif.exp_a = 8'd10; dif.exp_b = 8'd20;
      dif.start = 1'b1;
      @(negedge clk); cyc++;
      dif.start = 1'b0;
      while (dif.done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      n_checks++;
      if (cyc != 48) $display("FAIL busy_start_latency got %0d required 48", cyc);
      else n_pass++;
      n_checks++;
      if (dif.mantisa_mul !== 48'h6000_0000_0000 || dif.exponent_add !== 10'd127)
         $display("FAIL busy_start_result mant=%h exp=%h required 600000000000 07f",
                  dif.mantisa_mul, dif.exponent_add);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      int seen;
      @(negedge clk);
      dif.mant_a = 24'hC00000; dif.mant_b = 24'h800000; dif.exp_a = 8'd127; dif.exp_b = 8'd127;
      dif.start = 1'b1;
      @(negedge clk);
      dif.start = 1'b0;
      repeat (19) @(negedge clk);
      #2 arst = 1'b1;
      #1;
      n_checks++;
      if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.sel !== 1'b0 ||
          dif.mantisa_mul !== 48'h0 || dif.exponent_add !== 10'h0 || dif.div_by_zero !== 1'b0)
         $display("FAIL arst_immediate busy=%b done=%b sel=%b mant=%h exp=%h dbz=%b required all 0",
                  dif.busy, dif.done, dif.sel, dif.mantisa_mul, dif.exponent_add, dif.div_by_zero);
      else n_pass++;
      @(negedge clk);
      arst = 1'b0;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) $display("FAIL arst_no_done active_cycles=%0d required 0", seen);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [23:0] a, b;
      logic [7:0]  ea, eb;
      logic [47:0] q;
      logic [9:0]  e;
      logic        dz;
      int          cyc;
      run_div(24'hC00000, 24'h800000, 8'd127, 8'd127, cyc);
      a = {1'b1, 23'($urandom)}; b = {1'b1, 23'($urandom)};
      ea = 8'($urandom); eb = 8'($urandom);
      ref_div(a, b, ea, eb, q, e, dz);
      dif.mant_a = a; dif.mant_b = b; dif.exp_a = ea; dif.exp_b = eb;
      dif.start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dif.busy !== 1'b0 || dif.done !== 1'b0)
         $display("FAIL b2b_done_ignored busy=%b done=%b required 0 0", dif.busy, dif.done);
      else n_pass++;
      @(negedge clk);
      dif.start = 1'b0;
      n_checks++;
      if (dif.busy !== 1'b1) $display("FAIL b2b_accept busy=%b required 1", dif.busy);
      else n_pass++;
      cyc = 1;
      while (dif.done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      n_checks++;
      if (cyc != 48) $display("FAIL b2b_latency got %0d required 48", cyc);
      else n_pass++;
      n_checks++;
      if (dif.mantisa_mul !== q || dif.exponent_add !== e || dif.div_by_zero !== dz)
         $display("FAIL b2b_result mant=%h exp=%h dbz=%b required %h %h %b",
                  dif.mantisa_mul, dif.exponent_add, dif.div_by_zero, q, e, dz);
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      arst       = 1'b1;
      dif.en     = 1'b1;
      dif.start  = 1'b0;
      dif.mant_a = '0;
      dif.mant_b = '0;
      dif.exp_a  = '0;
      dif.exp_b  = '0;
      test_reset();
      test_directed();
      test_random();
      test_enable_stall();
      test_start_while_busy();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
